// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: FSM states, the buffered command
// record and the ALU select width.
package alu_seq_pkg;
  localparam int SEL_W = 3;
  localparam int ALU_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             c;
    logic [SEL_W-1:0] s;
  } cmd_t;
endpackage

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO, valid/ready on both sides; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  output logic o_ready,
  input  cmd_t i_data,
  output logic o_valid,
  input  logic i_ready,
  output cmd_t o_data
);
  localparam int AW = $clog2(DEPTH);

  cmd_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_valid && !w_full;
  assign w_pop   = i_ready && !w_empty;
  assign o_ready = !w_full;
  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered ALU commands one at a time: holds operands, pulses the shared
// system enable for LAT cycles, then captures O/Cout onto a valid/ready result port.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_c,
  input  logic [SEL_W-1:0] cmd_s,
  output logic             alu_enable,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_c,
  output logic [SEL_W-1:0] alu_s,
  input  logic [W-1:0]     alu_o,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_o,
  output logic             res_cout,
  output logic             busy
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;
  logic             w_enable;
  logic             w_head_vld;
  cmd_t             w_cmd_in;
  cmd_t             w_head;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic             r_alu_c;
  logic [SEL_W-1:0] r_alu_s;
  logic [W-1:0]     r_res_o;
  logic             r_res_cout;
  logic             r_res_valid;

  assign w_cmd_in = '{a: cmd_a, b: cmd_b, c: cmd_c, s: cmd_s};

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_valid (cmd_valid),
    .o_ready (cmd_ready),
    .i_data  (w_cmd_in),
    .o_valid (w_head_vld),
    .i_ready (w_pop),
    .o_data  (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_enable    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_head_vld) begin
          w_pop       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_enable = 1'b1;
        if (r_cnt == CW'(LAT - 1)) w_state_nxt = CAPTURE;
      end
      CAPTURE: w_state_nxt = HOLD;
      HOLD: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands load only on pop, so they cannot move while the enable is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_c     <= 1'b0;
      r_alu_s     <= '0;
      r_res_o     <= '0;
      r_res_cout  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a <= w_head.a;
        r_alu_b <= w_head.b;
        r_alu_c <= w_head.c;
        r_alu_s <= w_head.s;
        r_cnt   <= '0;
      end else if (r_state == ISSUE) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == CAPTURE) begin
        r_res_o     <= alu_o;
        r_res_cout  <= alu_cout;
        r_res_valid <= 1'b1;
      end else if ((r_state == HOLD) && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign alu_enable = w_enable;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_c      = r_alu_c;
  assign alu_s      = r_alu_s;
  assign res_valid  = r_res_valid;
  assign res_o      = r_res_o;
  assign res_cout   = r_res_cout;
  assign busy       = (r_state != IDLE) || w_head_vld;
endmodule
